// File: rtl/vend_ctrl_param.sv
// Parameterised vending-machine controller: coin credit, item vend, greedy change return,
// cancel and idle-timeout refund.
module vend_ctrl_param #(
  parameter int PRICE      = 25,
  parameter int MAX_CREDIT = 100,
  parameter int CREDIT_W   = 8,
  parameter int TIMEOUT    = 1000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_sel,
  input  logic                cancel,
  input  logic                item_taken,
  input  logic                change_ack,
  output logic                coin_accept,
  output logic                coin_reject,
  output logic                dispense,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          state
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_C     = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_CHANGE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CNT_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic                accept_q, accept_d;
  logic                reject_q, reject_d;
  logic [CREDIT_W-1:0] coin_val;
  logic                coin_fits;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] sel);
    case (sel)
      2'b00:   return CREDIT_W'(5);
      2'b01:   return CREDIT_W'(10);
      2'b10:   return CREDIT_W'(25);
      default: return '0;
    endcase
  endfunction

  // Largest coin not exceeding the amount still owed.
  function automatic logic [1:0] change_sel(input logic [CREDIT_W-1:0] amount);
    if (amount >= CREDIT_W'(25))      return 2'b10;
    else if (amount >= CREDIT_W'(10)) return 2'b01;
    else                              return 2'b00;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      credit_q   <= '0;
      idle_cnt_q <= '0;
      accept_q   <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      idle_cnt_q <= idle_cnt_d;
      accept_q   <= accept_d;
      reject_q   <= reject_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    idle_cnt_d = '0;
    accept_d   = 1'b0;
    reject_d   = 1'b0;
    coin_val   = coin_value(coin_sel);
    coin_fits  = coin_valid && (coin_sel != 2'b11) &&
                 (({1'b0, credit_q} + {1'b0, coin_val}) <= MAX_C);

    case (state_q)
      S_IDLE: begin
        accept_d = coin_fits;
        reject_d = coin_valid && !coin_fits;
        if (coin_fits) begin
          credit_d = credit_q + coin_val;
          state_d  = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (cancel) begin
          reject_d = coin_valid;
          state_d  = S_CHANGE;
        end else begin
          accept_d = coin_fits;
          reject_d = coin_valid && !coin_fits;
          // A coin landing on the vend edge still counts toward the change owed.
          if (credit_q >= PRICE_C) begin
            credit_d = (credit_q + (coin_fits ? coin_val : '0)) - PRICE_C;
            state_d  = S_VEND;
          end else if (coin_fits) begin
            credit_d = credit_q + coin_val;
          end else if (idle_cnt_q == CNT_LAST) begin
            state_d = S_CHANGE;
          end else begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
          end
        end
      end

      S_VEND: begin
        reject_d = coin_valid;
        if (item_taken) state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
      end

      default: begin
        reject_d = coin_valid;
        if (credit_q == '0) begin
          state_d = S_IDLE;
        end else if (change_ack) begin
          credit_d = credit_q - coin_value(change_sel(credit_q));
          if (credit_d == '0) state_d = S_IDLE;
        end
      end
    endcase
  end

  assign coin_accept  = accept_q;
  assign coin_reject  = reject_q;
  assign dispense     = (state_q == S_VEND);
  assign change_valid = (state_q == S_CHANGE) && (credit_q != '0);
  assign change_coin  = change_valid ? change_sel(credit_q) : 2'b00;
  assign credit       = credit_q;
  assign state        = state_q;

endmodule
